// File: rtl/torus_router_pkg.sv
// torus_pkg: shared constants and helpers for the torus router.
//   - port numbering used on every 5-bit vector
//   - flit width helpers (dest field + payload)
//   - route(): dimension-order (X then Y) routing, shortest way round each ring
package torus_pkg;

    localparam int P_XP    = 0;
    localparam int P_XN    = 1;
    localparam int P_YP    = 2;
    localparam int P_YN    = 3;
    localparam int P_LOCAL = 4;
    localparam int NPORTS  = 5;

    typedef logic [2:0] port_t;

    function automatic int idw_of(input int n);
        return $clog2(n * n);
    endfunction

    function automatic int flit_w(input int n, input int dw);
        return $clog2(n * n) + dw;
    endfunction

    // Out-of-range destinations are delivered locally; the caller flags them.
    // Ties on an even ring go the positive way.
    function automatic port_t route(input int dest, input int x, input int y, input int n);
        int dx;
        int dy;
        if (dest >= n * n) return port_t'(P_LOCAL);
        dx = ((dest % n) - x + n) % n;
        if (dx != 0) return (dx <= n - dx) ? port_t'(P_XP) : port_t'(P_XN);
        dy = ((dest / n) - y + n) % n;
        if (dy != 0) return (dy <= n - dy) ? port_t'(P_YP) : port_t'(P_YN);
        return port_t'(P_LOCAL);
    endfunction

endpackage

// File: rtl/torus_router_if.sv
// torus_router_if: the five-port valid/ready flit bundle of one router.
//   in_valid/in_data/in_ready    : flits entering the router, port p at [p*FW +: FW]
//   out_valid/out_data/out_ready : flits leaving the router, same packing
// master = traffic source/sink around the router, slave = the router itself.
interface torus_router_if #(parameter int FW = 12) ();

    logic [torus_pkg::NPORTS-1:0]    in_valid;
    logic [torus_pkg::NPORTS*FW-1:0] in_data;
    logic [torus_pkg::NPORTS-1:0]    in_ready;
    logic [torus_pkg::NPORTS-1:0]    out_valid;
    logic [torus_pkg::NPORTS*FW-1:0] out_data;
    logic [torus_pkg::NPORTS-1:0]    out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/torus_router_fifo.sv
// router_fifo: synchronous FIFO used as the per-input buffer of the router.
//   clk, rst_n (sync, active-low), push/din write side, pop/head read side,
//   full/empty status taken from the registered occupancy count.
module router_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] incr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = incr(wr_q);
        end
        if (do_pop) rd_d = incr(rd_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/torus_router.sv
// torus_router: single-flit five-port torus router.
//   clk, rst_n (sync, active-low)
//   bus          : torus_router_if.slave, ports 0=+x 1=-x 2=+y 3=-y 4=local
//   err_bad_dest : sticky, set when a flit with dest >= N*N is accepted
// Per-input FIFO -> combinational route on FIFO head -> per-output round-robin
// arbiter -> per-output register that reloads on the edge it is drained.
module torus_router
    import torus_pkg::*;
#(
    parameter int I     = 0,
    parameter int N     = 3,
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    torus_router_if.slave bus,
    output logic          err_bad_dest
);
    localparam int IDW = idw_of(N);
    localparam int FW  = flit_w(N, DW);
    localparam int X   = I % N;
    localparam int Y   = I / N;

    logic [NPORTS-1:0] push, pop, full, empty, bad;
    logic [FW-1:0]     head [NPORTS];
    port_t             rt   [NPORTS];

    logic [NPORTS-1:0] gnt_vld, can_load;
    port_t             gnt_idx [NPORTS];
    port_t             rr_q [NPORTS];
    port_t             rr_d [NPORTS];
    logic [NPORTS-1:0] ov_q, ov_d;
    logic [FW-1:0]     od_q [NPORTS];
    logic [FW-1:0]     od_d [NPORTS];
    logic              err_q, err_d;
    logic [NPORTS*FW-1:0] out_flat;

    for (genvar p = 0; p < NPORTS; p++) begin : g_in
        assign push[p] = bus.in_valid[p] & ~full[p];
        assign bad[p]  = int'(bus.in_data[p*FW+DW +: IDW]) >= N * N;
        assign rt[p]   = route(int'(head[p][FW-1 -: IDW]), X, Y, N);

        router_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[p]),
            .pop   (pop[p]),
            .din   (bus.in_data[p*FW +: FW]),
            .full  (full[p]),
            .empty (empty[p]),
            .head  (head[p])
        );
    end

    // An output register can take a new flit when empty or being drained now.
    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        assign can_load[o] = ~ov_q[o] | bus.out_ready[o];
    end

    always_comb begin
        int p;
        p       = 0;
        pop     = '0;
        gnt_vld = '0;
        for (int o = 0; o < NPORTS; o++) begin
            gnt_idx[o] = '0;
            for (int k = 0; k < NPORTS; k++) begin
                p = (int'(rr_q[o]) + k) % NPORTS;
                if (!gnt_vld[o] && !empty[p] && rt[p] == port_t'(o)) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = port_t'(p);
                end
            end
            if (gnt_vld[o] && can_load[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    always_comb begin
        ov_d  = ov_q;
        err_d = err_q | (|(push & bad));
        for (int o = 0; o < NPORTS; o++) begin
            od_d[o] = od_q[o];
            rr_d[o] = rr_q[o];
            if (gnt_vld[o] && can_load[o]) begin
                ov_d[o] = 1'b1;
                od_d[o] = head[gnt_idx[o]];
                rr_d[o] = (gnt_idx[o] == port_t'(NPORTS - 1)) ? '0 : gnt_idx[o] + port_t'(1);
            end else if (ov_q[o] && bus.out_ready[o]) begin
                ov_d[o] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ov_q  <= '0;
            err_q <= 1'b0;
            for (int o = 0; o < NPORTS; o++) begin
                od_q[o] <= '0;
                rr_q[o] <= '0;
            end
        end else begin
            ov_q  <= ov_d;
            err_q <= err_d;
            od_q  <= od_d;
            rr_q  <= rr_d;
        end
    end

    always_comb begin
        out_flat = '0;
        for (int o = 0; o < NPORTS; o++) out_flat[o*FW +: FW] = od_q[o];
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = out_flat;
    assign err_bad_dest  = err_q;

endmodule

// File: tb/tb_torus_router.sv
module tb_torus_router;
    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int IDW   = $clog2(N * N);
    localparam int FW    = IDW + DW;
    localparam int NP    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err4, err0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    torus_router_if #(.FW(FW)) bus4 ();
    torus_router_if #(.FW(FW)) bus0 ();

    torus_router #(.I(4), .N(N), .DW(DW), .DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .err_bad_dest(err4));
    torus_router #(.I(0), .N(N), .DW(DW), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .err_bad_dest(err0));

    logic [FW-1:0] exp_q [NP][NP][$];
    int seq [NP];
    int pushed = 0;
    int delivered = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mk(input int dest, input int pl);
        return {IDW'(dest), DW'(pl)};
    endfunction

    // Shortest way round each ring, X resolved before Y; ties go positive.
    function automatic int ref_route(input int me, input int dest);
        int fwd, bwd;
        if (dest >= N * N) return 4;
        fwd = (dest % N - me % N + N) % N;
        bwd = (me % N - dest % N + N) % N;
        if (fwd != 0) return (fwd <= bwd) ? 0 : 1;
        fwd = (dest / N - me / N + N) % N;
        bwd = (me / N - dest / N + N) % N;
        if (fwd != 0) return (fwd <= bwd) ? 2 : 3;
        return 4;
    endfunction

    function automatic logic [FW-1:0] od4(input int o);
        return bus4.out_data[o*FW +: FW];
    endfunction

    function automatic logic [FW-1:0] od0(input int o);
        return bus0.out_data[o*FW +: FW];
    endfunction

    // Account for everything that will transfer on the coming edge.
    task automatic scoreboard_pre_edge();
        logic [FW-1:0] f, e;
        int src;
        for (int p = 0; p < NP; p++) begin
            if (bus4.in_valid[p] && bus4.in_ready[p]) begin
                f = bus4.in_data[p*FW +: FW];
                exp_q[p][ref_route(4, int'(f[FW-1 -: IDW]))].push_back(f);
                seq[p]++;
                pushed++;
            end
        end
        for (int o = 0; o < NP; o++) begin
            if (bus4.out_valid[o] && bus4.out_ready[o]) begin
                f   = od4(o);
                src = int'(f[DW-1 -: 3]);
                if (src < NP && exp_q[src][o].size() > 0) e = exp_q[src][o].pop_front();
                else e = ~f;
                check($sformatf("rand_out%0d", o), 64'(f), 64'(e));
                delivered++;
            end
        end
    endtask

    initial begin
        int acc;
        int sq;
        int remaining;
        logic [NP-1:0] stall;
        logic [FW-1:0] sd [NP];

        bus4.in_valid  = '0;
        bus4.in_data   = '0;
        bus4.out_ready = '1;
        bus0.in_valid  = '0;
        bus0.in_data   = '0;
        bus0.out_ready = '1;
        for (int p = 0; p < NP; p++) seq[p] = 0;

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 64'(bus4.in_ready), 64'h1f);
        check("rst_out_valid", 64'(bus4.out_valid), 64'h0);
        check("rst_out_data", 64'(bus4.out_data), 64'h0);
        check("rst_err", 64'(err4), 64'h0);

        // Local inject, then latency of one edge to the +x output.
        bus4.in_valid[4] = 1'b1;
        bus4.in_data[4*FW +: FW] = mk(5, 8'hA5);
        step();
        bus4.in_valid[4] = 1'b0;
        check("lat_not_yet", 64'(bus4.out_valid[0]), 64'h0);
        step();
        check("lat_valid", 64'(bus4.out_valid[0]), 64'h1);
        check("lat_data", 64'(od4(0)), 64'(mk(5, 8'hA5)));
        step();
        check("lat_drained", 64'(bus4.out_valid), 64'h0);

        // Two inputs contend for +x: lower index after rr wins first.
        bus4.in_valid[1] = 1'b1;
        bus4.in_data[1*FW +: FW] = mk(5, 8'h11);
        bus4.in_valid[4] = 1'b1;
        bus4.in_data[4*FW +: FW] = mk(5, 8'h44);
        step();
        bus4.in_valid = '0;
        step();
        check("arb_first", 64'(od4(0)), 64'(mk(5, 8'h11)));
        step();
        check("arb_second_v", 64'(bus4.out_valid[0]), 64'h1);
        check("arb_second", 64'(od4(0)), 64'(mk(5, 8'h44)));
        step();
        check("arb_drained", 64'(bus4.out_valid[0]), 64'h0);

        // Backpressure capacity on the local -> +x path.
        bus4.out_ready[0] = 1'b0;
        acc = 0;
        sq  = 0;
        for (int c = 0; c < 6; c++) begin
            bus4.in_valid[4] = 1'b1;
            bus4.in_data[4*FW +: FW] = mk(5, 8'hB0 + sq);
            if (bus4.in_ready[4]) acc++;
            step();
            if (acc > sq) sq++;
        end
        bus4.in_valid[4] = 1'b0;
        check("bp_accepted", 64'(acc), 64'(1 + DEPTH));
        check("bp_in_ready", 64'(bus4.in_ready[4]), 64'h0);
        check("bp_held", 64'(od4(0)), 64'(mk(5, 8'hB0)));
        bus4.out_ready[0] = 1'b1;
        for (int i = 0; i < 1 + DEPTH; i++) begin
            check($sformatf("bp_valid%0d", i), 64'(bus4.out_valid[0]), 64'h1);
            check($sformatf("bp_data%0d", i), 64'(od4(0)), 64'(mk(5, 8'hB0 + i)));
            step();
        end
        check("bp_empty", 64'(bus4.out_valid[0]), 64'h0);

        // Routing from core 0, including the wrap-around shortcut.
        for (int i = 0; i < 3; i++) begin
            int d;
            int ep;
            d  = (i == 0) ? 2 : (i == 1) ? 6 : 0;
            ep = ref_route(0, d);
            bus0.in_valid[4] = 1'b1;
            bus0.in_data[4*FW +: FW] = mk(d, 8'h30 + i);
            step();
            bus0.in_valid[4] = 1'b0;
            step();
            check($sformatf("i0_port_d%0d", d), 64'(bus0.out_valid), 64'(1 << ep));
            check($sformatf("i0_data_d%0d", d), 64'(od0(ep)), 64'(mk(d, 8'h30 + i)));
            step();
        end

        // Random traffic against the per-(input,output) order model.
        stall = '0;
        for (int c = 0; c < 400; c++) begin
            for (int o = 0; o < NP; o++) begin
                if (stall[o]) begin
                    check($sformatf("hold_v%0d", o), 64'(bus4.out_valid[o]), 64'h1);
                    check($sformatf("hold_d%0d", o), 64'(od4(o)), 64'(sd[o]));
                end
            end
            for (int p = 0; p < NP; p++) begin
                bus4.in_valid[p] = 1'($urandom_range(0, 1));
                bus4.in_data[p*FW +: FW] = mk($urandom_range(0, N * N - 1), (p << 5) | (seq[p] & 31));
                bus4.out_ready[p] = ($urandom_range(0, 3) != 0);
            end
            for (int o = 0; o < NP; o++) begin
                stall[o] = bus4.out_valid[o] & ~bus4.out_ready[o];
                sd[o]    = od4(o);
            end
            scoreboard_pre_edge();
            step();
        end
        bus4.in_valid  = '0;
        bus4.out_ready = '1;
        for (int c = 0; c < 20; c++) begin
            scoreboard_pre_edge();
            step();
        end
        remaining = 0;
        for (int p = 0; p < NP; p++)
            for (int o = 0; o < NP; o++) remaining += exp_q[p][o].size();
        check("rand_remaining", 64'(remaining), 64'h0);
        check("rand_count", 64'(delivered), 64'(pushed));
        check("rand_err_clean", 64'(err4), 64'h0);

        // Out-of-range destination: delivered locally, flag sticks.
        bus4.in_valid[4] = 1'b1;
        bus4.in_data[4*FW +: FW] = mk(9, 8'h99);
        step();
        bus4.in_valid[4] = 1'b0;
        check("bad_err_set", 64'(err4), 64'h1);
        step();
        check("bad_port", 64'(bus4.out_valid), 64'h10);
        check("bad_data", 64'(od4(4)), 64'(mk(9, 8'h99)));
        bus4.in_valid[3] = 1'b1;
        bus4.in_data[3*FW +: FW] = mk(1, 8'h5C);
        step();
        bus4.in_valid[3] = 1'b0;
        step();
        check("legal_after_bad", 64'(od4(ref_route(4, 1))), 64'(mk(1, 8'h5C)));
        check("bad_err_sticky", 64'(err4), 64'h1);
        step();

        // Reset with flits buffered.
        bus4.out_ready[0] = 1'b0;
        bus4.in_valid[4] = 1'b1;
        bus4.in_data[4*FW +: FW] = mk(5, 8'hE1);
        step();
        bus4.in_data[4*FW +: FW] = mk(5, 8'hE2);
        step();
        bus4.in_valid[4] = 1'b0;
        check("pre_rst_busy", 64'(bus4.out_valid[0]), 64'h1);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 64'(bus4.out_valid), 64'h0);
        check("mid_rst_ready", 64'(bus4.in_ready), 64'h1f);
        check("mid_rst_data", 64'(bus4.out_data), 64'h0);
        check("mid_rst_err", 64'(err4), 64'h0);
        rst_n = 1'b1;
        bus4.out_ready = '1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("post_rst_quiet%0d", c), 64'(bus4.out_valid), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
